sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares one single-port `sram` instance between two requesters: m0 (instruction fetch) and m1 (load/store unit).
- Arbitration uses fixed priority to m1, a starvation guard for m0, and an m1 lock for atomic read-modify-write sequences.
- Drives the SRAM enable, address, write data and byte strobes, and routes the 1-cycle-latency read data and ack back to the granted requester.
- Sits between the core's memory ports and the on-chip `sram`.

Parameters:
- LEN_ADDR, 32, address width of both requesters and of the SRAM port.
- LEN_DATA, 32, data width; byte strobes are LEN_DATA/8 bits.
- STARVE_LIMIT, 4, consecutive cycles m0 may be denied while requesting before it is forced; 0 = pure m1 priority, no guard.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req_valid  in  1  m0 request.
- m0_req_ready  out  1  m0 granted this cycle.
- m0_addr  in  LEN_ADDR  m0 byte address.
- m0_wdata  in  LEN_DATA  m0 write data.
- m0_wstrb  in  LEN_DATA/8  m0 byte strobes; 0 = read.
- m0_resp_valid  out  1  m0 response/ack, one cycle after grant.
- m0_rdata  out  LEN_DATA  m0 read data, valid with m0_resp_valid.
- m1_req_valid, m1_req_ready, m1_addr, m1_wdata, m1_wstrb, m1_resp_valid, m1_rdata: as m0, for m1.
- m1_lock  in  1  m1 holds the SRAM across consecutive requests.
- sram_en  out  1  to sram ena.
- sram_addr  out  LEN_ADDR  to sram addra.
- sram_wdata  out  LEN_DATA  to sram dina.
- sram_wea  out  LEN_DATA/8  to sram wea.
- sram_rdata  in  LEN_DATA  from sram douta.

Behaviour:
- Reset values: state=OPEN, starve_cnt=0, both resp_valid=0, owner=none. Async assert; deassert is synchronous to clk.
- Grant is combinational in the request cycle: req_ready = grant.
  - The transfer happens when valid && ready.
  - A requester holds addr/wdata/wstrb stable while valid && !ready.
- sram_en = grant0 | grant1. sram_addr, sram_wdata and sram_wea are muxed from the granted master. When no grant: sram_en=0, sram_wea=0, addr/data are don't-care.
- Latency is 1 cycle:
  - mX_resp_valid is registered, equal to grantX of the previous cycle, and issued for reads and writes alike.
  - mX_rdata = sram_rdata, gated to 0 when mX_resp_valid=0.
  - There is no response backpressure; requesters always accept responses.
- Back-to-back grants are allowed every cycle, including write followed by a read of the same address. The SRAM merges the pending write, so the read returns the new data; no stall is inserted.
- States:
  - OPEN: priority is m1 > m0, unless (STARVE_LIMIT>0 && starve_cnt==STARVE_LIMIT && m0_req_valid), which grants m0.
  - LOCKED: m0 is never granted, even at the starvation limit; m1 is granted whenever valid.
- Transitions:
  - OPEN->LOCKED when m1 is granted with m1_lock=1.
  - LOCKED->OPEN on any cycle with m1_lock=0; that cycle arbitrates as OPEN.
  - LOCKED stays LOCKED while m1_lock=1, with or without an m1 request.
- starve_cnt has width $clog2(STARVE_LIMIT+1):
  - Clears when m0 is granted or m0_req_valid=0.
  - Increments, saturating at STARVE_LIMIT, when m0_req_valid=1 and m0 is not granted.
  - Keeps counting while LOCKED.
- On leaving LOCKED with a saturated starve_cnt, m0 wins the first OPEN cycle.
- Reset mid-operation clears an outstanding response: no resp_valid after reset deasserts. An SRAM write already issued completes inside the `sram`.

Decomposition:
- Shared package `mem_pkg`: arb_state_t enum (ARB_OPEN, ARB_LOCKED), owner_t enum (OWN_NONE, OWN_M0, OWN_M1).
- Single module; no sub-module. The grant logic is an always_comb block inside this module.

Test Plan:
- Reset with both requesting -> during reset: ready=0, sram_en=0, resp_valid=0. After release: m1 granted first.
- m1 write addr 0x8, wdata 0xDEADBEEF, wstrb 0xF, then m0 read 0x8 next cycle -> m0_resp_valid one cycle after its grant, m0_rdata=0xDEADBEEF.
- Partial write: m1 wstrb 0x3, wdata 0x0000_1234 over 0xDEADBEEF, then read -> 0xDEAD1234.
- Both requesting continuously, STARVE_LIMIT=4 -> grant pattern m1,m1,m1,m1,m0 repeating; starve_cnt never exceeds 4.
- m1_lock=1 for 8 cycles with m0 requesting -> m0_req_ready=0 throughout. On the first cycle with m1_lock=0, m0 is granted (counter saturated).
- rst_n pulsed low in the cycle after an m0 read grant -> m0_resp_valid stays 0. The next m0 read of the same address returns the stored value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: arbiter FSM state and response owner.
package mem_pkg;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } owner_t;

endpackage : mem_pkg

// File: rtl/sram_arbiter.sv
// Two-master arbiter for a single-port SRAM: m1 priority, m0 starvation guard,
// m1 lock for atomic sequences, 1-cycle response routing.
module sram_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LEN_ADDR     = 32,
  parameter int unsigned LEN_DATA     = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic [LEN_ADDR-1:0]   m0_addr,
  input  logic [LEN_DATA-1:0]   m0_wdata,
  input  logic [LEN_DATA/8-1:0] m0_wstrb,
  output logic                  m0_resp_valid,
  output logic [LEN_DATA-1:0]   m0_rdata,

  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic [LEN_ADDR-1:0]   m1_addr,
  input  logic [LEN_DATA-1:0]   m1_wdata,
  input  logic [LEN_DATA/8-1:0] m1_wstrb,
  output logic                  m1_resp_valid,
  output logic [LEN_DATA-1:0]   m1_rdata,
  input  logic                  m1_lock,

  output logic                  sram_en,
  output logic [LEN_ADDR-1:0]   sram_addr,
  output logic [LEN_DATA-1:0]   sram_wdata,
  output logic [LEN_DATA/8-1:0] sram_wea,
  input  logic [LEN_DATA-1:0]   sram_rdata
);

  localparam int unsigned LEN_STRB  = LEN_DATA / 8;
  localparam int unsigned CNT_W     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic        GUARD_EN  = (STARVE_LIMIT > 0);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  owner_t           r_owner;

  arb_state_t       w_state_d;
  logic [CNT_W-1:0] w_starve_cnt_d;
  owner_t           w_owner_d;
  logic             w_locked;
  logic             w_force0;
  logic             w_grant0;
  logic             w_grant1;

  // A LOCKED cycle with m1_lock low already arbitrates as OPEN.
  always_comb begin
    w_locked = (r_state == ARB_LOCKED) && m1_lock;
    w_force0 = GUARD_EN && !w_locked && m0_req_valid && (r_starve_cnt == CNT_MAX);
    w_grant0 = rst_n && (w_force0 || (!w_locked && m0_req_valid && !m1_req_valid));
    w_grant1 = rst_n && m1_req_valid && !w_force0;
  end

  always_comb begin
    w_state_d = ARB_OPEN;
    if (m1_lock && ((r_state == ARB_LOCKED) || w_grant1)) begin
      w_state_d = ARB_LOCKED;
    end

    w_starve_cnt_d = r_starve_cnt;
    if (!m0_req_valid || w_grant0) begin
      w_starve_cnt_d = '0;
    end else if (r_starve_cnt < CNT_MAX) begin
      w_starve_cnt_d = r_starve_cnt + 1'b1;
    end

    w_owner_d = OWN_NONE;
    if (w_grant1) begin
      w_owner_d = OWN_M1;
    end else if (w_grant0) begin
      w_owner_d = OWN_M0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_OPEN;
      r_starve_cnt <= '0;
      r_owner      <= OWN_NONE;
    end else begin
      r_state      <= w_state_d;
      r_starve_cnt <= w_starve_cnt_d;
      r_owner      <= w_owner_d;
    end
  end

  always_comb begin
    m0_req_ready = w_grant0;
    m1_req_ready = w_grant1;
    sram_en      = w_grant0 | w_grant1;
    sram_addr    = w_grant1 ? m1_addr  : m0_addr;
    sram_wdata   = w_grant1 ? m1_wdata : m0_wdata;
    sram_wea     = LEN_STRB'(0);
    if (w_grant1) begin
      sram_wea = m1_wstrb;
    end else if (w_grant0) begin
      sram_wea = m0_wstrb;
    end
  end

  always_comb begin
    m0_resp_valid = (r_owner == OWN_M0);
    m1_resp_valid = (r_owner == OWN_M1);
    m0_rdata      = m0_resp_valid ? sram_rdata : '0;
    m1_rdata      = m1_resp_valid ? sram_rdata : '0;
  end

endmodule : sram_arbiter
